// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   UART transmitter with an integrated byte FIFO. Characters pushed by the
//   upstream message logic are serialised back-to-back onto txd_pin as
//   start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   wr_en       push wr_data into the FIFO this cycle (dropped when full)
//   wr_data     character to transmit, DATA_BITS wide
//   full        FIFO holds DEPTH entries (registered)
//   empty       FIFO holds 0 entries (registered)
//   level       FIFO occupancy (registered)
//   txd_pin     serial line, idle high (registered)
//   busy        high while a frame is on the line (registered)
//   frame_done  one-cycle pulse during the last cycle of each frame's stop bits
module uart_frame_tx #(
  parameter int CLK_HZ    = 100000000,
  parameter int BIT_RATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_BITS-1:0]     wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     txd_pin,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int AW  = $clog2(DEPTH);
  localparam int BCW = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CPB - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]    FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic           ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          level_q, level_d;
  logic                 full_q, empty_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // Writes are gated by the registered full flag, so a pop in the same
  // cycle never makes room for a push that arrives while full.
  assign push = wr_en & ~full_q;
  assign head = mem_q[rptr_q];

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [BCW-1:0]       baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_last;
  logic                 load;

  assign baud_last = (baud_q == BAUD_LAST);

  // Line outputs are registered from the current state, so txd/busy/
  // frame_done all trail the state register by one cycle and stay aligned.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    txd_d   = 1'b1;
    busy_d  = (state_q != S_IDLE);
    done_d  = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty_q) load = 1'b1;
      end
      S_START: begin
        txd_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        txd_d = shreg_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        txd_d = par_q;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            // Chain straight into the next start bit when data is waiting.
            if (!empty_q) load = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shreg_d = head;
      par_d   = (^head) ^ ODD_PAR;
      baud_d  = '0;
      bit_d   = '0;
      state_d = S_START;
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign txd_pin    = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx
//   Scoreboard bench for uart_frame_tx: 7 data bits, odd parity, 2 stop
//   bits, 4 clocks per bit, 4-entry FIFO. Stimulus pushes expected
//   characters into exp_q; an independent line monitor decodes every frame
//   and checks it against a reference waveform built from the frame rules.
module tb_uart_frame_tx;

  localparam int CLK_HZ = 100;
  localparam int BAUD   = 25;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DB     = 7;
  localparam int PAR    = 2;
  localparam int SB     = 2;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int F      = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DB-1:0] wr_data;
  logic          full, empty, txd_pin, busy, frame_done;
  logic [LW-1:0] level;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] bq[$];
  bit            mon_busy = 1'b0;

  uart_frame_tx #(
    .CLK_HZ   (CLK_HZ),
    .BIT_RATE (BAUD),
    .DATA_BITS(DB),
    .PARITY   (PAR),
    .STOP_BITS(SB),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .txd_pin   (txd_pin),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int ones(input logic [DB-1:0] d);
    int n = 0;
    for (int i = 0; i < DB; i++) n += (d[i] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  function automatic logic par_bit(input logic [DB-1:0] d);
    // even: make the total count of ones even; odd: make it odd
    if (PAR == 1) return logic'(ones(d) % 2 == 1);
    return logic'(ones(d) % 2 == 0);
  endfunction

  // Expected line level at cycle c of a frame carrying d.
  function automatic logic line_bit(input int c, input logic [DB-1:0] d);
    int b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    if (PAR != 0 && b == DB + 1) return par_bit(d);
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Line monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [DB-1:0] exp, got;
    logic          par_got;
    int            bad_cyc, done_first, done_cnt, busy_low;
    bit            aborted, have_exp, chk_gap, chk_idle;
    chk_gap  = 1'b0;
    chk_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        chk_gap  = 1'b0;
        chk_idle = 1'b0;
      end else begin
        if (chk_gap) check("gapless_start", 32'(txd_pin), 32'd0);
        if (chk_idle) begin
          check("line_idle_after_frame", 32'(txd_pin), 32'd1);
          check("busy_fall", 32'(busy), 32'd0);
        end
        chk_gap  = 1'b0;
        chk_idle = 1'b0;
        if (txd_pin === 1'b0) begin
          mon_busy = 1'b1;
          have_exp = (exp_q.size() != 0);
          if (have_exp) begin
            exp = exp_q.pop_front();
          end else begin
            exp = '1;
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got a start bit, expected no frame (t=%0t)", $time);
          end
          aborted = 1'b0; bad_cyc = 0; done_first = -1; done_cnt = 0; busy_low = 0;
          got = '0; par_got = 1'b0;
          for (int c = 0; c < F; c++) begin
            if (c != 0) @(negedge clk);
            if (reset !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (txd_pin !== line_bit(c, exp)) bad_cyc++;
            if (c % CPB == CPB / 2) begin
              if (c / CPB >= 1 && c / CPB <= DB) got[c/CPB-1] = txd_pin;
              if (PAR != 0 && c / CPB == DB + 1) par_got = txd_pin;
            end
            if (frame_done === 1'b1) begin
              if (done_cnt == 0) done_first = c;
              done_cnt++;
            end
            if (busy !== 1'b1) busy_low++;
          end
          if (!aborted && have_exp) begin
            check("frame_data", 32'(got), 32'(exp));
            check("parity_bit", 32'(par_got), 32'(par_bit(exp)));
            check("frame_bad_cycles", 32'(bad_cyc), 32'd0);
            check("frame_done_pos", 32'(done_first), 32'(F - 1));
            check("frame_done_width", 32'(done_cnt), 32'd1);
            check("busy_low_in_frame", 32'(busy_low), 32'd0);
          end
          if (!aborted) begin
            if (exp_q.size() != 0) chk_gap = 1'b1;
            else                   chk_idle = 1'b1;
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_drain(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_pending", 32'(exp_q.size()) + 32'(mon_busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_level", 32'(level), 32'd0);
  endtask

  // Pushes bq on consecutive cycles starting from an idle, empty FIFO.
  // From idle the head is popped on the second edge, so DEPTH+1 bytes fit.
  task automatic run_burst(input bit drain);
    int n     = bq.size();
    int acc   = (n < DEPTH + 1) ? n : DEPTH + 1;
    int steps = (n > 3) ? n : 3;
    int lvl;
    for (int i = 0; i < steps; i++) begin
      wr_en = (i < n);
      if (i < n) wr_data = bq[i];
      if (i < acc) exp_q.push_back(bq[i]);
      @(posedge clk); #1;
      if (i == 1) check("latency_not_early", 32'(txd_pin), 32'd1);
      if (i == 2) begin
        check("latency_txd_low", 32'(txd_pin), 32'd0);
        check("busy_rise", 32'(busy), 32'd1);
      end
      if (i == n - 1) begin
        lvl = acc - ((n >= 2) ? 1 : 0);
        check("burst_level", 32'(level), 32'(lvl));
        check("burst_full", 32'(full), 32'(lvl == DEPTH));
        check("burst_empty", 32'(empty), 32'(lvl == 0));
      end
    end
    wr_en = 1'b0;
    if (drain) wait_drain((n + 2) * F + 20);
  endtask

  initial begin : stim
    int bad;
    int n;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd_pin), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    reset = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (txd_pin !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 ||
          level !== '0 || full !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", 32'(bad), 32'd0);

    bq = {7'h03};
    run_burst(1'b1);
    bq = {7'h61, 7'h62};
    run_burst(1'b1);
    bq = {7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15};
    run_burst(1'b1);
    bq = {7'h00, 7'h7f};
    run_burst(1'b1);

    repeat (12) begin
      n = $urandom_range(DEPTH + 2, 1);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(DB'($urandom()));
      run_burst(1'b1);
    end

    // Abort during the data bits of the second queued character.
    bq = {7'h55, 7'h2a, 7'h33};
    run_burst(1'b0);
    repeat (F + 8) @(posedge clk);
    #1;
    check("busy_before_reset", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_txd", 32'(txd_pin), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_frame_done", 32'(frame_done), 32'd0);
    check("abort_empty", 32'(empty), 32'd1);
    check("abort_level", 32'(level), 32'd0);
    check("abort_full", 32'(full), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (txd_pin !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || level !== '0) bad++;
    end
    check("post_abort_quiet_cycles", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
